// File: rtl/attn_read_sched.sv
// ---------------------------------------------------------------------------
// attn_read_sched
//
// Round-robin scheduler that time-shares a single attn_reader datapath
// between NUM_REQ requesters (one per attention query/head stream).
//
// A requester is granted, its index is driven on sel so the surrounding
// operand muxes route its score/v_mat to the reader, the reader is kicked
// with a one-cycle start pulse, and the scheduler then waits for the
// reader's out_valid under a watchdog. The result is returned as a tagged
// response with a ready/valid handshake. The reader's out_vec stays stable
// through RESP because no new start is issued, so the consumer captures
// data on the response handshake.
//
// Parameters:
//   NUM_REQ   number of requesters (>= 2)
//   TIMEOUT   maximum cycles spent waiting for the reader (>= 2)
//   ID_W      width of the requester index
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   req        level request per requester, held until its ack
//   ack        one-hot, one-cycle pulse when a request is accepted
//   sel        index of the current owner (reader operand mux select)
//   rd_start   one-cycle start pulse to the reader
//   rd_valid   reader out_valid
//   rsp_valid  response available
//   rsp_id     owner of the response (same value as sel)
//   rsp_err    1 = watchdog expired, reader output is not valid
//   rsp_ready  consumer accepts the response
//   busy       high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module attn_read_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [ID_W-1:0]    sel,
  output logic               rd_start,
  input  logic               rd_valid,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_err,
  input  logic               rsp_ready,
  output logic               busy
);

  // The timer only has to reach TIMEOUT-1 before the FSM leaves WAIT,
  // so it can never wrap.
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   owner_nxt;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_nxt;
  logic              err;
  logic              err_nxt;

  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic              pick_found;
  int unsigned       cand_raw;

  // Round-robin arbiter: first set request bit at or above ptr, wrapping
  // back to 0. The wrap is done with a compare-and-subtract rather than a
  // modulo so it stays cheap for NUM_REQ values that are not powers of two.
  // The result only matters when at least one request is set.
  always_comb begin
    pick       = ptr;
    pick_found = 1'b0;
    cand       = '0;
    cand_raw   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_raw = int'(unsigned'(ptr)) + i;
      if (cand_raw >= NUM_REQ) begin
        cand_raw = cand_raw - NUM_REQ;
      end
      cand = ID_W'(cand_raw);
      if (!pick_found && req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // State register together with the owner, round-robin pointer, watchdog
  // timer and error flag. Reset aborts any transaction in flight without
  // producing a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      timer <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      timer <= timer_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state logic and Moore output decode. Requests are only looked at
  // in IDLE, so a request that drops before its ack is simply never seen.
  // rd_valid is only honoured in WAIT; a late pulse after a timeout lands
  // in RESP or IDLE and is ignored. When rd_valid and the final watchdog
  // cycle coincide, the valid result takes priority.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    timer_nxt = timer;
    err_nxt   = err;

    ack       = '0;
    rd_start  = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    sel       = owner;
    rsp_id    = owner;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt = pick;
          state_nxt = LAUNCH;
        end
      end

      LAUNCH: begin
        ack[owner] = 1'b1;
        rd_start   = 1'b1;
        timer_nxt  = '0;
        state_nxt  = WAIT;
      end

      WAIT: begin
        timer_nxt = timer + 1'b1;
        if (rd_valid) begin
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (timer == TMR_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err;
        if (rsp_ready) begin
          ptr_nxt   = (owner == LAST_ID) ? '0 : owner + 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_attn_read_sched.sv
// ---------------------------------------------------------------------------
// tb_attn_read_sched
//
// Self-checking bench for attn_read_sched (NUM_REQ=4, TIMEOUT=8) with a
// small attn_reader stand-in whose out_valid rises SEQ_LEN cycles after it
// samples start. A transaction-level model tracks the age of the current
// grant and derives every DUT output from it each cycle; directed sections
// pin the model with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_attn_read_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam int SEQ_LEN = 3;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      ack;
  logic [1:0]      sel;
  logic            rd_start;
  logic            rd_valid;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            rsp_err;
  logic            rsp_ready;
  logic            busy;

  logic            reader_en;
  logic            inject_rv;
  logic [3:0]      rd_cnt;
  logic            rd_pulse;

  int              checks;
  int              errors;

  attn_read_sched #(
    .NUM_REQ (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .rd_start  (rd_start),
    .rd_valid  (rd_valid),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reader stand-in: out_valid is high for one cycle, SEQ_LEN edges after
  // the edge that sampled start. reader_en=0 stubs it out; inject_rv lets
  // the bench force extra pulses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= 4'd0;
      rd_pulse <= 1'b0;
    end else begin
      rd_pulse <= (rd_cnt == 4'd1);
      if (rd_start) begin
        rd_cnt <= 4'(SEQ_LEN);
      end else if (rd_cnt != 4'd0) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
    end
  end

  assign rd_valid = (reader_en & rd_pulse) | inject_rv;

  // Single comparison point; every mismatch reports one FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; requesters drop the bit that was just acknowledged.
  task automatic waitCycle();
    @(posedge clk);
    #1;
    req = req & ~ack;
  endtask

  // One cycle of random traffic for the soak phase.
  task automatic applyStimulus();
    logic [1:0] victim;
    waitCycle();
    for (int b = 0; b < NREQ; b++) begin
      if (!req[b] && $urandom_range(0, 5) == 0) req[b] = 1'b1;
    end
    if ($urandom_range(0, 40) == 0) begin
      victim = 2'($urandom_range(0, 3));
      req[victim] = 1'b0;
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
    inject_rv = ($urandom_range(0, 19) == 0);
    if ($urandom_range(0, 59) == 0) reader_en = ~reader_en;
  endtask

  function automatic int ackIndex(input logic [3:0] a);
    int r;
    r = -1;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (a[k]) r = k;
    end
    return r;
  endfunction

  // Transaction model. m_age counts cycles since the grant (age 0 is the
  // launch cycle, ages 1..TIMEOUT are the wait window); m_done is the age
  // at which the response appears once the outcome is known.
  int m_active;
  int m_age;
  int m_done;
  int m_owner;
  int m_ptr;
  int m_err;

  initial begin
    m_active = 0;
    m_age    = 0;
    m_done   = -1;
    m_owner  = 0;
    m_ptr    = 0;
    m_err    = 0;
  end

  always @(negedge clk) begin
    int  in_resp;
    int  launch;
    int  idx;
    int  found;
    logic [31:0] e_ack;

    if (rst) begin
      m_active = 0;
      m_age    = 0;
      m_done   = -1;
      m_owner  = 0;
      m_ptr    = 0;
      m_err    = 0;
    end

    in_resp = (m_active != 0 && m_done >= 0 && m_age >= m_done) ? 1 : 0;
    launch  = (m_active != 0 && m_age == 0) ? 1 : 0;
    e_ack   = (launch != 0) ? (32'd1 << m_owner) : 32'd0;

    checkOutput("model_ack",       32'(ack),       e_ack);
    checkOutput("model_rd_start",  32'(rd_start),  32'(launch));
    checkOutput("model_busy",      32'(busy),      32'(m_active != 0));
    checkOutput("model_sel",       32'(sel),       32'(m_owner));
    checkOutput("model_rsp_valid", 32'(rsp_valid), 32'(in_resp));
    checkOutput("model_rsp_id",    32'(rsp_id),    32'(m_owner));
    checkOutput("model_rsp_err",   32'(rsp_err),   (in_resp != 0) ? 32'(m_err) : 32'd0);

    if (!rst) begin
      if (m_active == 0) begin
        if (req != 4'd0) begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (found == 0 && ((req >> idx) & 4'd1) != 4'd0) begin
              m_owner = idx;
              found   = 1;
            end
          end
          m_active = 1;
          m_age    = 0;
          m_done   = -1;
        end
      end else if (in_resp != 0) begin
        if (rsp_ready) begin
          m_active = 0;
          m_ptr    = (m_owner + 1) % NREQ;
        end
      end else begin
        if (m_age >= 1 && m_done < 0) begin
          if (rd_valid) begin
            m_done = m_age + 1;
            m_err  = 0;
          end else if (m_age == TIMEOUT) begin
            m_done = TIMEOUT + 1;
            m_err  = 1;
          end
        end
        m_age++;
      end
    end
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] simulation time bound exceeded");
  end

  int g_id  [8];
  int g_cyc [8];
  int n;

  // Record grants over a bounded window.
  task automatic collectGrants(input int cycles);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      g_id[k]  = -1;
      g_cyc[k] = -1;
    end
    for (int c = 0; c < cycles; c++) begin
      waitCycle();
      if (rd_start) begin
        if (n < 8) begin
          g_id[n]  = ackIndex(ack);
          g_cyc[n] = c;
        end
        n++;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    req       = 4'd0;
    rsp_ready = 1'b1;
    reader_en = 1'b1;
    inject_rv = 1'b0;

    #1 rst = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("reset_ack",       32'(ack),       32'd0);
    checkOutput("reset_sel",       32'(sel),       32'd0);
    checkOutput("reset_rd_start",  32'(rd_start),  32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("reset_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    waitCycle();
    waitCycle();
    rst = 1'b0;

    // All four requesting: grants 0,1,2,3, seven cycles apart.
    $display("[TB] round-robin fairness");
    req = 4'b1111;
    collectGrants(40);
    checkOutput("rr_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr_order%0d", k), 32'(g_id[k]), 32'(k));
    end
    for (int k = 1; k < 4; k++) begin
      checkOutput($sformatf("rr_spacing%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd7);
    end

    // After id 3 was served the pointer wraps to 0.
    $display("[TB] wrap-around");
    req = 4'b1001;
    collectGrants(30);
    checkOutput("wrap_count", 32'(n), 32'd2);
    checkOutput("wrap_first", 32'(g_id[0]), 32'd0);
    checkOutput("wrap_second", 32'(g_id[1]), 32'd3);

    // Single request: ack/start in cycle 0->1, response at edge 5.
    $display("[TB] single request");
    req = 4'b0100;
    waitCycle();
    checkOutput("single_ack",      32'(ack),      32'b0100);
    checkOutput("single_rd_start", 32'(rd_start), 32'd1);
    checkOutput("single_sel",      32'(sel),      32'd2);
    repeat (4) waitCycle();
    checkOutput("single_not_early", 32'(rsp_valid), 32'd0);
    waitCycle();
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_rsp_id",    32'(rsp_id),    32'd2);
    checkOutput("single_rsp_err",   32'(rsp_err),   32'd0);
    waitCycle();
    checkOutput("single_busy_fall", 32'(busy), 32'd0);

    // Watchdog: reader silent, error response at edge 9, late pulses ignored.
    $display("[TB] timeout");
    reader_en = 1'b0;
    rsp_ready = 1'b0;
    req       = 4'b0010;
    waitCycle();
    checkOutput("to_ack", 32'(ack), 32'b0010);
    repeat (8) waitCycle();
    checkOutput("to_not_early", 32'(rsp_valid), 32'd0);
    waitCycle();
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_err",   32'(rsp_err),   32'd1);
    checkOutput("to_rsp_id",    32'(rsp_id),    32'd1);
    inject_rv = 1'b1;
    waitCycle();
    inject_rv = 1'b0;
    checkOutput("to_late_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_late_err",   32'(rsp_err),   32'd1);
    rsp_ready = 1'b1;
    waitCycle();
    checkOutput("to_idle", 32'(busy), 32'd0);
    inject_rv = 1'b1;
    waitCycle();
    inject_rv = 1'b0;
    checkOutput("to_idle_stale", 32'(busy), 32'd0);
    waitCycle();
    checkOutput("to_idle_stale2", 32'(busy), 32'd0);

    // rd_valid on the last watchdog cycle (timer==7) wins over the timeout.
    $display("[TB] simultaneous valid and timeout");
    req = 4'b0100;
    waitCycle();
    checkOutput("sim_ack", 32'(ack), 32'b0100);
    repeat (8) waitCycle();
    inject_rv = 1'b1;
    checkOutput("sim_not_early", 32'(rsp_valid), 32'd0);
    waitCycle();
    inject_rv = 1'b0;
    checkOutput("sim_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("sim_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("sim_rsp_id",    32'(rsp_id),    32'd2);
    waitCycle();

    // Backpressure: response held for 10 cycles with another request pending.
    $display("[TB] backpressure and reset");
    reader_en = 1'b1;
    rsp_ready = 1'b0;
    req       = 4'b0001;
    waitCycle();
    checkOutput("bp_ack", 32'(ack), 32'b0001);
    repeat (5) waitCycle();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    req = req | 4'b0010;
    for (int k = 0; k < 10; k++) begin
      waitCycle();
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_hold_id",    32'(rsp_id),    32'd0);
      checkOutput("bp_hold_ack",   32'(ack),       32'd0);
    end
    rsp_ready = 1'b1;
    waitCycle();
    checkOutput("bp_release", 32'(busy), 32'd0);
    waitCycle();
    checkOutput("bp_next_grant", 32'(ack), 32'b0010);
    repeat (2) waitCycle();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy",      32'(busy),      32'd0);
    checkOutput("rst_mid_sel",       32'(sel),       32'd0);
    checkOutput("rst_mid_ack",       32'(ack),       32'd0);
    checkOutput("rst_mid_rd_start",  32'(rd_start),  32'd0);
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_rsp_id",    32'(rsp_id),    32'd0);
    waitCycle();
    rst = 1'b0;
    req = 4'b0011;
    waitCycle();
    checkOutput("rst_first_grant", 32'(ack), 32'b0001);
    repeat (20) waitCycle();

    // Random soak against the model.
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
    end
    req       = 4'd0;
    rsp_ready = 1'b1;
    inject_rv = 1'b0;
    repeat (20) waitCycle();
    checkOutput("drain_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
